// File: rtl/key_filter.sv
// Keyboard code filter: debounces a held USB keycode, emits a press pulse,
// then auto-repeat pulses after a hold delay while the key stays down.
module key_filter #(
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned HOLD_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [7:0] raw_keycode_i,
    output logic [7:0] keycode_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int unsigned CNT_W = 25;
    localparam int unsigned KEY_W = 8;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        REPEAT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   cand_q, cand_d;
    logic [KEY_W-1:0]   raw_q, raw_d;
    logic [KEY_W-1:0]   keycode_q, keycode_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q, key_held_d;
    logic               pulse;

    function automatic logic is_accepted(input logic [KEY_W-1:0] code);
        case (code)
            8'h1A, 8'h04, 8'h16, 8'h07, 8'h28: is_accepted = 1'b1;
            default:                           is_accepted = 1'b0;
        endcase
    endfunction

    // Rejected codes collapse to "no key"; a disabled filter sees no key, so
    // re-enabling with a key held starts from a fresh sample.
    assign raw_d = (enable_i && is_accepted(raw_keycode_i)) ? raw_keycode_i : KEY_W'(0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        pulse   = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (raw_q != KEY_W'(0)) begin
                        cand_d  = raw_q;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (raw_q != cand_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == STABLE_LAST) begin
                        pulse   = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (raw_q != cand_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == HOLD_LAST) begin
                        pulse   = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (raw_q != cand_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == REPEAT_LAST) begin
                        pulse = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output stage: pulse payload for one cycle, held level follows current state.
    always_comb begin
        keycode_d   = pulse ? cand_q : KEY_W'(0);
        key_valid_d = pulse;
        key_held_d  = enable_i && ((state_q == HOLD) || (state_q == REPEAT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            raw_q       <= '0;
            keycode_q   <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            raw_q       <= raw_d;
            keycode_q   <= keycode_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign keycode_o   = keycode_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with short timing parameters (4/10/3).
module tb_key_filter;

    logic       clk;
    logic       rst_n;
    logic       enable_i;
    logic [7:0] raw_keycode_i;
    logic [7:0] keycode_o;
    logic       key_valid_o;
    logic       key_held_o;

    int n_checks;
    int n_pass;

    key_filter #(
        .STABLE_CYCLES(4),
        .HOLD_DELAY   (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .raw_keycode_i(raw_keycode_i),
        .keycode_o    (keycode_o),
        .key_valid_o  (key_valid_o),
        .key_held_o   (key_held_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int e, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, e, obs, exp);
    endtask

    task automatic chk_out(input string tag, input int e, input logic [7:0] code,
                           input logic valid, input logic held);
        chk({tag, ".keycode"}, e, keycode_o, code);
        chk({tag, ".valid"}, e, 8'(key_valid_o), 8'(valid));
        chk({tag, ".held"}, e, 8'(key_held_o), 8'(held));
    endtask

    // Apply inputs, then sample just after the rising edge they are captured on.
    task automatic cyc(input logic [7:0] code, input logic en);
        raw_keycode_i = code;
        enable_i      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1);
    endtask

    initial begin
        logic v;
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        enable_i      = 1'b1;
        raw_keycode_i = 8'h00;
        #12;
        chk_out("reset", -1, 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        cyc(8'h00, 1'b1);
        chk_out("post_reset", 0, 8'h00, 1'b0, 1'b0);
        settle();

        // ENTER press, hold delay, auto-repeat, release
        for (int e = 0; e <= 31; e++) begin
            cyc((e <= 27) ? 8'h28 : 8'h00, 1'b1);
            v = (e == 5) || (e == 15) || (e == 18) || (e == 21) || (e == 24) || (e == 27);
            chk_out("enter", e, v ? 8'h28 : 8'h00, v, (e >= 6) && (e <= 29));
        end
        settle();

        // Bouncing W never settles long enough
        for (int e = 0; e <= 15; e++) begin
            cyc(((e <= 2) || ((e >= 4) && (e <= 6))) ? 8'h1A : 8'h00, 1'b1);
            chk_out("bounce", e, 8'h00, 1'b0, 1'b0);
        end
        settle();

        // Unaccepted code is ignored
        for (int e = 0; e < 50; e++) begin
            cyc(8'h05, 1'b1);
            chk_out("reject", e, 8'h00, 1'b0, 1'b0);
        end
        settle();

        // W then direct switch to D
        for (int e = 0; e <= 20; e++) begin
            cyc((e <= 5) ? 8'h1A : 8'h07, 1'b1);
            if (e == 5)       chk_out("w_to_d", e, 8'h1A, 1'b1, 1'b0);
            else if (e == 12) chk_out("w_to_d", e, 8'h07, 1'b1, 1'b0);
            else chk_out("w_to_d", e, 8'h00, 1'b0, (e == 6) || (e == 7) || (e >= 13));
        end
        settle();

        // A held across an enable drop
        for (int e = 0; e <= 40; e++) begin
            cyc(8'h04, !((e >= 20) && (e <= 24)));
            v = (e == 5) || (e == 15) || (e == 18) || (e == 30) || (e == 40);
            chk_out("enable", e, v ? 8'h04 : 8'h00, v, ((e >= 6) && (e <= 19)) || (e >= 31));
        end
        settle();

        // S repeating, then asynchronous reset between edges
        for (int e = 0; e <= 19; e++) begin
            cyc(8'h16, 1'b1);
            v = (e == 5) || (e == 15) || (e == 18);
            chk_out("s_pre_rst", e, v ? 8'h16 : 8'h00, v, e >= 6);
        end
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            cyc(8'h16, 1'b1);
            chk_out("s_post_rst", e, (e == 5) ? 8'h16 : 8'h00, e == 5, e >= 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter STABLE_CYCLES, default 500000, sets the debounce length in clocks; it SHALL be at least 1.
REQ-002 Parameter HOLD_DELAY, default 25000000, sets the clocks from the first pulse to the first auto-repeat pulse; it SHALL be at least 1.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, sets the clocks between auto-repeat pulses; it SHALL be at least 1.
REQ-004 Clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  filter enable; low forces idle.
REQ-007 raw_keycode  in  8  held keyboard code from the USB host; 0x00 means no key.
REQ-008 keycode  out  8  filtered code; equals the accepted key only during a pulse cycle, else 0x00.
REQ-009 key_valid  out  1  one-cycle strobe marking a press or repeat event.
REQ-010 key_held  out  1  level; high while an accepted key remains held after its first pulse.

Function
REQ-011 raw_keycode SHALL be registered once (raw_q), and the FSM SHALL act on raw_q only.
REQ-012 Only the codes W=0x1A, A=0x04, S=0x16, D=0x07 and ENTER=0x28 SHALL be accepted; any other code SHALL be treated as 0x00.
REQ-013 FSM states SHALL be IDLE, DEBOUNCE, HOLD and REPEAT, with a shared 25-bit counter cnt and an 8-bit candidate register cand.
REQ-014 IDLE: if raw_q is accepted, the FSM SHALL load cand<=raw_q, set cnt<=0 and go to DEBOUNCE.
REQ-015 DEBOUNCE: if raw_q!=cand, go to IDLE; else if cnt==STABLE_CYCLES-1, emit a pulse, set cnt<=0 and go to HOLD; else increment cnt.
REQ-016 HOLD: if raw_q!=cand, go to IDLE; else if cnt==HOLD_DELAY-1, emit a pulse, set cnt<=0 and go to REPEAT; else increment cnt.
REQ-017 REPEAT: if raw_q!=cand, go to IDLE; else if cnt==REPEAT_PERIOD-1, emit a pulse and set cnt<=0; else increment cnt.
REQ-018 Emitting a pulse SHALL register keycode<=cand and key_valid<=1 for exactly one cycle; in all other cycles keycode SHALL be 0x00 and key_valid SHALL be 0.
REQ-019 The first pulse SHALL appear STABLE_CYCLES+1 cycles after the edge at which raw_keycode=K is first sampled, provided K is held throughout.
REQ-020 A release (raw_q!=cand) SHALL produce no pulse and SHALL return the FSM to IDLE within one cycle.
REQ-021 A direct change from one accepted key to another SHALL pass through IDLE, so the new key's first pulse appears STABLE_CYCLES+2 cycles after the change is sampled.
REQ-022 key_held SHALL be registered high exactly while the state is HOLD or REPEAT.
REQ-023 enable low SHALL force the state to IDLE, keycode to 0x00, key_valid to 0 and key_held to 0 on the next edge; no pulse SHALL occur while enable is low.
REQ-024 When enable returns high with a key still held, the key SHALL require a full debounce before its next pulse.
REQ-025 If the enable-low condition and a pulse condition coincide on the same edge, enable SHALL win and no pulse SHALL be emitted.
REQ-026 A timeout and a release on the same edge SHALL resolve as a release: no pulse, go to IDLE.

Reset
REQ-027 Reset low SHALL immediately, independent of Clk, set the state to IDLE and clear cnt, cand, raw_q, keycode, key_valid and key_held.
REQ-028 Reset asserted mid-operation SHALL abort any debounce or repeat; after release, only new key samples SHALL produce pulses.
REQ-029 Outputs SHALL be 0x00/0/0 on the first clock after Reset deasserts.

Verification (STABLE_CYCLES=4, HOLD_DELAY=10, REPEAT_PERIOD=3, enable=1)
REQ-030 ENTER (0x28) sampled at edges 0..27, then 0x00 -> keycode=0x28 with key_valid at cycles 5, 15, 18, 21, 24 and 27 only; key_held high from cycle 6 until release.
REQ-031 Bounce pattern 0x1A x3, 0x00 x1, 0x1A x3, then 0x00 -> no key_valid at any time.
REQ-032 0x05 held for 50 cycles -> keycode stays 0x00, key_valid and key_held stay 0.
REQ-033 W held to its first pulse (cycle 5), then D from edge 6 held -> D pulse at cycle 12, no W pulse after cycle 5.
REQ-034 A held, enable dropped at cycle 20 for 5 cycles, then raised with A still held -> no pulses while enable is low; next pulse 5 cycles after enable is sampled high; key_held 0 in between.
REQ-035 S held in REPEAT, Reset pulled low asynchronously between edges -> keycode=0x00, key_valid=0 and key_held=0 before the next edge; after release, the first pulse appears STABLE_CYCLES+1 cycles after S is resampled.
